// File: rtl/sound_scheduler.sv
// One-shot sound request arbiter for the codec sample player: fixed priority,
// preemption by higher-priority requesters, and a silent gap between sounds.
module sound_scheduler #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DUR_WIDTH  = 12,
  parameter int unsigned GAP_CYCLES = 8,
  parameter int unsigned ID_WIDTH   = 2
) (
  input  logic                         xck_clock,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           req_sel,
  input  logic [NUM_REQ*DUR_WIDTH-1:0] req_frames,
  input  logic                         frame_tick,
  output logic                         sound_input,
  output logic                         sound_sample_select,
  output logic                         busy,
  output logic [ID_WIDTH-1:0]          active_id,
  output logic                         done,
  output logic                         aborted
);

  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_e;

  state_e                 state_q, state_d;
  logic [NUM_REQ-1:0]     pending_q, pending_d;
  logic [NUM_REQ-1:0]     sel_q, sel_d;
  logic [DUR_WIDTH-1:0]   frames_q [NUM_REQ];
  logic [DUR_WIDTH-1:0]   frames_d [NUM_REQ];
  logic [DUR_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic [ID_WIDTH-1:0]    active_id_q, active_id_d;
  logic                   smp_sel_q, smp_sel_d;
  logic                   done_q, done_d;
  logic                   aborted_q, aborted_d;

  logic                   any_pend;
  logic                   found;
  logic                   higher_pend;
  logic [ID_WIDTH-1:0]    grant_idx;
  logic [NUM_REQ-1:0]     clr;

  always_ff @(posedge xck_clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      sel_q       <= '0;
      frames_q    <= '{default: '0};
      frame_cnt_q <= '0;
      gap_cnt_q   <= '0;
      active_id_q <= '0;
      smp_sel_q   <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      sel_q       <= sel_d;
      frames_q    <= frames_d;
      frame_cnt_q <= frame_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      active_id_q <= active_id_d;
      smp_sel_q   <= smp_sel_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  always_comb begin
    any_pend    = |pending_q;
    found       = 1'b0;
    higher_pend = 1'b0;
    grant_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pending_q[i] && !found) begin
        found     = 1'b1;
        grant_idx = ID_WIDTH'(i);
      end
      if (pending_q[i] && (i < 32'(active_id_q))) higher_pend = 1'b1;
    end

    state_d     = state_q;
    clr         = '0;
    frame_cnt_d = frame_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    active_id_d = active_id_q;
    smp_sel_d   = smp_sel_q;
    done_d      = 1'b0;
    aborted_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable && any_pend) begin
          state_d         = PLAY;
          clr[grant_idx]  = 1'b1;
          frame_cnt_d     = frames_q[grant_idx];
          active_id_d     = grant_idx;
          smp_sel_d       = sel_q[grant_idx];
        end
      end
      PLAY: begin
        // Completion is checked first so it wins over a coincident preemption.
        if (frame_tick && frame_cnt_q == DUR_WIDTH'(1)) begin
          state_d   = GAP;
          done_d    = 1'b1;
          gap_cnt_d = GAP_W'(GAP_CYCLES);
        end else if (!enable || higher_pend) begin
          state_d   = GAP;
          aborted_d = 1'b1;
          gap_cnt_d = GAP_W'(GAP_CYCLES);
        end else if (frame_tick) begin
          frame_cnt_d = frame_cnt_q - DUR_WIDTH'(1);
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q - GAP_W'(1);
        if (gap_cnt_q == GAP_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new request in the grant cycle re-sets the bit just cleared.
    pending_d = pending_q & ~clr;
    sel_d     = sel_q;
    frames_d  = frames_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req[i] && (req_frames[i*DUR_WIDTH +: DUR_WIDTH] != '0)) begin
        pending_d[i] = 1'b1;
        sel_d[i]     = req_sel[i];
        frames_d[i]  = req_frames[i*DUR_WIDTH +: DUR_WIDTH];
      end
    end
  end

  always_comb begin
    sound_input         = (state_q == PLAY);
    busy                = (state_q != IDLE);
    sound_sample_select = smp_sel_q;
    active_id           = active_id_q;
    done                = done_q;
    aborted             = aborted_q;
  end

endmodule

// File: tb/tb_sound_scheduler.sv
// Directed bench for sound_scheduler: a table of single-request plays plus
// hand-written sequences for arbitration, preemption, enable and reset.
module tb_sound_scheduler;

  logic        xck_clock = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [3:0]  req;
  logic [3:0]  req_sel;
  logic [47:0] req_frames;
  logic        frame_tick;
  logic        sound_input;
  logic        sound_sample_select;
  logic        busy;
  logic [1:0]  active_id;
  logic        done;
  logic        aborted;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int abort_seen = 0;

  sound_scheduler #(
    .NUM_REQ   (4),
    .DUR_WIDTH (12),
    .GAP_CYCLES(8),
    .ID_WIDTH  (2)
  ) dut (
    .xck_clock          (xck_clock),
    .rst_n              (rst_n),
    .enable             (enable),
    .req                (req),
    .req_sel            (req_sel),
    .req_frames         (req_frames),
    .frame_tick         (frame_tick),
    .sound_input        (sound_input),
    .sound_sample_select(sound_sample_select),
    .busy               (busy),
    .active_id          (active_id),
    .done               (done),
    .aborted            (aborted)
  );

  always #5 xck_clock = ~xck_clock;

  typedef struct {
    int id;
    int sel;
    int frames;
    int period;
    int exp_id;
    int exp_sel;
    int exp_high;
    int exp_done;
    int exp_gap;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge xck_clock);
    #1;
    if (done) done_seen++;
    if (aborted) abort_seen++;
  endtask

  task automatic pulse_req(input int id, input logic sel, input int f);
    req[id] = 1'b1;
    req_sel[id] = sel;
    req_frames[id*12 +: 12] = 12'(f);
    step();
    req = '0;
  endtask

  task automatic tick_steps(input int n);
    for (int k = 0; k < n; k++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
    end
  endtask

  // Low samples counted from the current one up to the next rise of sound_input.
  task automatic count_low(output int n);
    n = 0;
    while (!sound_input && n < 50) begin
      n++;
      step();
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy && g < 50) begin
      g++;
      step();
    end
    chk("wait_idle_bound", int'(busy), 0);
  endtask

  initial begin
    int high, s, g, d0, a0, n;

    vecs[0] = '{id:2, sel:1, frames:3, period:20, exp_id:2, exp_sel:1, exp_high:60, exp_done:1, exp_gap:8};
    vecs[1] = '{id:0, sel:0, frames:1, period:5,  exp_id:0, exp_sel:0, exp_high:5,  exp_done:1, exp_gap:8};
    vecs[2] = '{id:3, sel:1, frames:2, period:3,  exp_id:3, exp_sel:1, exp_high:6,  exp_done:1, exp_gap:8};
    vecs[3] = '{id:1, sel:0, frames:4, period:1,  exp_id:1, exp_sel:0, exp_high:4,  exp_done:1, exp_gap:8};

    rst_n = 1'b0;
    enable = 1'b1;
    req = '0;
    req_sel = '0;
    req_frames = '0;
    frame_tick = 1'b0;
    #12;
    chk("rst_sound_input", int'(sound_input), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_active_id", int'(active_id), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_aborted", int'(aborted), 0);
    chk("rst_sel", int'(sound_sample_select), 0);
    @(posedge xck_clock);
    #1 rst_n = 1'b1;
    step();

    // Single-request table
    for (int e = 0; e < 4; e++) begin
      d0 = done_seen;
      a0 = abort_seen;
      pulse_req(vecs[e].id, 1'(vecs[e].sel), vecs[e].frames);
      chk("no_rise_at_latch", int'(sound_input), 0);
      step();
      chk("rise_after_grant", int'(sound_input), 1);
      chk("tbl_active_id", int'(active_id), vecs[e].exp_id);
      chk("tbl_sel", int'(sound_sample_select), vecs[e].exp_sel);
      high = 1;
      s = 0;
      while (sound_input && s < 2000) begin
        s++;
        frame_tick = (s % vecs[e].period == 0);
        step();
        frame_tick = 1'b0;
        if (sound_input) high++;
      end
      chk("tbl_high_cycles", high, vecs[e].exp_high);
      chk("tbl_done_cnt", done_seen - d0, vecs[e].exp_done);
      g = 0;
      while (busy && g < 50) begin
        g++;
        step();
      end
      chk("tbl_gap_cycles", g, vecs[e].exp_gap);
      chk("tbl_abort_cnt", abort_seen - a0, 0);
    end

    // Simultaneous requests: lower index first, then gap, then the other
    d0 = done_seen;
    req_frames[1*12 +: 12] = 12'd2;
    req_frames[3*12 +: 12] = 12'd2;
    req_sel[1] = 1'b0;
    req_sel[3] = 1'b1;
    req = 4'b1010;
    step();
    req = '0;
    step();
    chk("sim_first_id", int'(active_id), 1);
    chk("sim_first_sel", int'(sound_sample_select), 0);
    tick_steps(2);
    chk("sim_first_done", int'(done), 1);
    count_low(n);
    chk("sim_gap_low", n, 9);
    chk("sim_second_id", int'(active_id), 3);
    chk("sim_second_sel", int'(sound_sample_select), 1);
    tick_steps(2);
    chk("sim_done_total", done_seen - d0, 2);
    wait_idle();

    // Preemption of requester 3 by requester 0
    d0 = done_seen;
    a0 = abort_seen;
    pulse_req(3, 1'b0, 10);
    step();
    tick_steps(2);
    pulse_req(0, 1'b1, 1);
    chk("pre_still_playing", int'(sound_input), 1);
    step();
    chk("pre_aborted", int'(aborted), 1);
    chk("pre_sound_low", int'(sound_input), 0);
    count_low(n);
    chk("pre_gap_low", n, 9);
    chk("pre_new_id", int'(active_id), 0);
    tick_steps(1);
    wait_idle();
    repeat (20) step();
    chk("pre_no_replay", int'(busy), 0);
    chk("pre_done_cnt", done_seen - d0, 1);
    chk("pre_abort_cnt", abort_seen - a0, 1);

    // Completion and preemption in the same cycle
    pulse_req(2, 1'b0, 1);
    step();
    frame_tick = 1'b1;
    req[0] = 1'b1;
    req_sel[0] = 1'b1;
    req_frames[0 +: 12] = 12'd3;
    step();
    frame_tick = 1'b0;
    req = '0;
    chk("coin_done", int'(done), 1);
    chk("coin_aborted", int'(aborted), 0);
    count_low(n);
    chk("coin_gap_low", n, 9);
    chk("coin_new_id", int'(active_id), 0);
    chk("coin_new_sel", int'(sound_sample_select), 1);
    tick_steps(3);
    wait_idle();

    // Enable low aborts and blocks grants; raise grants on the next cycle
    pulse_req(1, 1'b1, 5);
    step();
    enable = 1'b0;
    step();
    chk("en_aborted", int'(aborted), 1);
    chk("en_sound_low", int'(sound_input), 0);
    pulse_req(1, 1'b0, 2);
    repeat (12) step();
    chk("en_no_grant_busy", int'(busy), 0);
    chk("en_no_grant_sound", int'(sound_input), 0);
    enable = 1'b1;
    step();
    chk("en_grant_sound", int'(sound_input), 1);
    chk("en_grant_id", int'(active_id), 1);
    tick_steps(2);
    chk("en_done", int'(done), 1);
    wait_idle();

    // Zero-duration request is ignored
    pulse_req(2, 1'b1, 0);
    repeat (5) step();
    chk("zero_no_grant", int'(busy), 0);

    // Re-request of the active id, with a tick in the grant cycle
    d0 = done_seen;
    a0 = abort_seen;
    pulse_req(1, 1'b0, 2);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    pulse_req(1, 1'b1, 1);
    step();
    chk("rereq_no_self_preempt", int'(sound_input), 1);
    tick_steps(1);
    chk("rereq_grant_tick_uncounted", int'(sound_input), 1);
    tick_steps(1);
    chk("rereq_first_done", int'(done), 1);
    count_low(n);
    chk("rereq_gap_low", n, 9);
    chk("rereq_id", int'(active_id), 1);
    chk("rereq_sel", int'(sound_sample_select), 1);
    tick_steps(1);
    chk("rereq_done_cnt", done_seen - d0, 2);
    chk("rereq_abort_cnt", abort_seen - a0, 0);
    wait_idle();

    // Asynchronous reset mid-play with a pending re-request
    pulse_req(3, 1'b1, 5);
    step();
    pulse_req(3, 1'b1, 5);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_sound_input", int'(sound_input), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_active_id", int'(active_id), 0);
    chk("arst_sel", int'(sound_sample_select), 0);
    @(posedge xck_clock);
    #1 rst_n = 1'b1;
    repeat (15) step();
    chk("arst_no_stale_grant", int'(busy), 0);
    chk("arst_sound_after", int'(sound_input), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sound_scheduler.md
Name: sound_scheduler

Overview:
Arbitrates one-shot sound requests from game-logic requesters onto the single audio playback path. It drives the playback trigger (sound_input) and the sample selection (sound_sample_select) of the codec sample player. Each accepted request plays for a requested number of audio frames. Runs in the codec master-clock domain, with fixed priority and preemption, and enforces a silent gap so every new sound produces a fresh trigger edge downstream.

Parameters:
NUM_REQ, 4, number of requesters; index 0 has highest priority
DUR_WIDTH, 12, width of the per-request duration field, in frames
GAP_CYCLES, 8, xck_clock cycles sound_input is held low between sounds; must be >= 4 to cover the downstream synchronizer and edge detector
ID_WIDTH, 2, width of active_id; must be >= clog2(NUM_REQ)

Ports:
xck_clock  input  1  codec master clock; all logic on its rising edge
rst_n  input  1  asynchronous, active-low reset
enable  input  1  global sound enable; low blocks grants and aborts the current sound
req  input  NUM_REQ  one-cycle request pulses, already in the xck_clock domain
req_sel  input  NUM_REQ  per-requester sample select, sampled with req (1 = quack, 0 = sine)
req_frames  input  NUM_REQ*DUR_WIDTH  per-requester duration in frames, sampled with req; slice i is [i*DUR_WIDTH +: DUR_WIDTH]
frame_tick  input  1  one-cycle pulse per LR-clock rising edge, i.e. one per frame
sound_input  output  1  playback trigger level to the sample player
sound_sample_select  output  1  sample select to the sample player
busy  output  1  high in any state other than IDLE
active_id  output  ID_WIDTH  index of the last granted requester
done  output  1  one-cycle pulse when a sound completes its full duration
aborted  output  1  one-cycle pulse when a sound is cut short by preemption or by enable going low

Behaviour:
- Reset values: every output 0, state IDLE, all pending bits and latched parameters cleared.
- Request latch:
  - req[i]=1 with nonzero req_frames slice: pending[i] is set and sel_i/frames_i are latched.
  - A repeat request while pending[i] is already set overwrites sel_i/frames_i.
  - req[i] with a zero duration is ignored.
  - A set and a clear of pending[i] in the same cycle: set wins.
- FSM states: IDLE, PLAY, GAP.
- IDLE:
  - If enable=1 and any pending bit is set, grant the lowest-indexed pending requester g in that cycle.
  - Grant actions: clear pending[g], load frame_cnt = frames_g, set active_id = g, set sound_sample_select = sel_g, go to PLAY.
  - sound_input rises on the cycle after the grant decision.
- PLAY:
  - sound_input = 1.
  - Each frame_tick decrements frame_cnt. A frame_tick in the grant cycle is not counted.
  - frame_tick while frame_cnt == 1: next cycle sound_input = 0, done pulses for 1 cycle, gap_cnt = GAP_CYCLES, go to GAP.
- Preemption, checked in PLAY:
  - Condition: a pending requester j with j < active_id, or enable = 0.
  - Next cycle: sound_input = 0, aborted pulses for 1 cycle, go to GAP.
  - The preempted request is dropped and done does not pulse.
  - If completion and preemption coincide, completion wins (done pulses, aborted does not).
- GAP:
  - sound_input = 0.
  - gap_cnt decrements every cycle; at 1, go to IDLE.
  - IDLE can grant on its first cycle, so sound_input stays low for exactly GAP_CYCLES+1 cycles between sounds.
- sound_sample_select changes only on a grant; it holds its value through PLAY, GAP and IDLE.
- The current requester re-requesting during its own PLAY is queued as pending and plays after the GAP; it does not preempt itself.
- enable = 0 in IDLE or GAP: no grants, pending bits retained.
- Reset asserted mid-sound: immediate return to reset values, pending requests lost.
- All counters are saturating-free. frame_cnt never reaches 0 in PLAY because zero-duration requests are rejected.

Test Plan:
- Single request, req[2] with sel=1, frames=3, ticks every 20 cycles -> sound_input high 1 cycle after grant; falls 1 cycle after the 3rd counted tick; done=1 once; sound_sample_select=1; active_id=2.
- Simultaneous req[1] and req[3], frames=2 each -> requester 1 plays first. sound_input stays low exactly GAP_CYCLES+1=9 cycles, then requester 3 plays; two done pulses in total.
- Preemption: requester 3 playing with frames=10, req[0] after 2 ticks -> aborted pulse; sound_input low 9 cycles; requester 0 granted; requester 3 is not replayed.
- Completion and preemption coincide: req[0] arrives in the same cycle as the final frame_tick of requester 2 -> done=1, aborted=0; requester 0 granted after the gap.
- Enable: drop enable mid-PLAY -> aborted and sound_input 0. Issue req[1] while enable=0 -> no grant, busy=0 after the gap. Raise enable -> requester 1 granted on the next cycle.
- Edge cases: req with frames=0 produces no grant. Re-request of the active id during PLAY plays again after the gap. Reset asserted during PLAY clears all outputs asynchronously, and no stale pending grant occurs after release.
